// File: rtl/ddr_pkg.sv
// Shared definitions for the DRAM command/response device model:
// command encodings, error codes, address field positions, bank states.
package ddr_pkg;

    // C_S command encodings
    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ACT = 4'd1;
    localparam logic [3:0] CMD_RD  = 4'd2;
    localparam logic [3:0] CMD_WR  = 4'd3;
    localparam logic [3:0] CMD_PRE = 4'd4;

    // err_code values reported for a rejected command
    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL  = 3'd1;
    localparam logic [2:0] ERR_ACT_OPEN = 3'd2;
    localparam logic [2:0] ERR_CLOSED   = 3'd3;
    localparam logic [2:0] ERR_TRCD     = 3'd4;
    localparam logic [2:0] ERR_TRP      = 3'd5;
    localparam logic [2:0] ERR_TCCD     = 3'd6;

    // Address field positions: bank above the row, column at the bottom
    localparam int ADR_BANK_LSB = 28;
    localparam int ADR_ROW_LSB  = 12;
    localparam int ADR_ROW_W    = 16;

    // OPENING/PRECHARGING are the open/closed states with the bank timer running
    typedef enum logic [1:0] {
        BANK_CLOSED      = 2'd0,
        BANK_OPENING     = 2'd1,
        BANK_OPEN        = 2'd2,
        BANK_PRECHARGING = 2'd3
    } bank_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dram_bank_fsm.sv
// One DRAM bank: open/closed state, latched row and the shared tRCD/tRP timer.
// The timer means tRCD while opening and tRP while precharging.
// Handshake: i_act/i_pre are single-cycle strobes that the decoder raises only
// when o_ready_act / o_open say the command is legal; the FSM trusts them.
module dram_bank_fsm
    import ddr_pkg::*;
#(
    parameter int TW    = 4,
    parameter int T_ACT = 8,
    parameter int T_PRE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_act,
    input  logic                 i_pre,
    input  logic [ADR_ROW_W-1:0] i_row,
    output logic                 o_open,
    output logic                 o_ready_act,
    output logic                 o_ready_col,
    output bank_state_e          o_state,
    output logic [ADR_ROW_W-1:0] o_row
);

    localparam logic [TW-1:0] ACT_LOAD = TW'(T_ACT - 1);
    localparam logic [TW-1:0] PRE_LOAD = TW'(T_PRE - 1);
    localparam logic [TW-1:0] ONE      = TW'(1);

    bank_state_e          r_state;
    bank_state_e          w_state_nxt;
    logic [TW-1:0]        r_timer;
    logic [TW-1:0]        w_timer_nxt;
    logic [ADR_ROW_W-1:0] r_row;
    logic [ADR_ROW_W-1:0] w_row_nxt;

    // State, timer and row registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= BANK_CLOSED;
            r_timer <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // Next state: the timer counts down and saturates; a timed state is left
    // on the edge where the timer reaches zero so the bank is usable next edge
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = (r_timer != '0) ? r_timer - ONE : '0;
        w_row_nxt   = r_row;
        case (r_state)
            BANK_CLOSED: begin
                if (i_act) begin
                    w_row_nxt   = i_row;
                    w_timer_nxt = ACT_LOAD;
                    w_state_nxt = (ACT_LOAD == '0) ? BANK_OPEN : BANK_OPENING;
                end
            end
            BANK_OPENING, BANK_OPEN: begin
                if (i_pre) begin
                    w_timer_nxt = PRE_LOAD;
                    w_state_nxt = (PRE_LOAD == '0) ? BANK_CLOSED : BANK_PRECHARGING;
                end else if (r_state == BANK_OPENING && r_timer <= ONE) begin
                    w_state_nxt = BANK_OPEN;
                end
            end
            BANK_PRECHARGING: begin
                if (r_timer <= ONE) begin
                    w_state_nxt = BANK_CLOSED;
                end
            end
            default: w_state_nxt = BANK_CLOSED;
        endcase
    end

    assign o_open      = (r_state == BANK_OPENING) || (r_state == BANK_OPEN);
    assign o_ready_act = (r_state == BANK_CLOSED);
    assign o_ready_col = (r_state == BANK_OPEN);
    assign o_state     = r_state;
    assign o_row       = r_row;

endmodule

// File: rtl/dram_cmd_resp.sv
// DRAM device-side responder: decodes C_S/adrs every cycle, enforces
// tRCD/tRP/tCCD, returns read bursts after CL and captures write bursts
// after CWL into a small array. Rejected commands pulse err for one cycle.
module dram_cmd_resp
    import ddr_pkg::*;
#(
    parameter int NB    = 4,
    parameter int CL    = 4,
    parameter int CWL   = 3,
    parameter int BL    = 4,
    parameter int t_act = 8,
    parameter int t_pre = 8,
    parameter int DW    = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    C_S,
    input  logic [31:0]   adrs,
    input  logic [DW-1:0] wr_dq,
    output logic [DW-1:0] rd_dq,
    output logic          rd_valid,
    output logic [NB-1:0] bank_open,
    output logic          err,
    output logic [2:0]    err_code
);

    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = $clog2(max3(t_act, t_pre, BL) + 1);
    localparam int AW = BW + CW;
    localparam logic [TW-1:0] CCD_LOAD  = TW'(BL - 1);
    localparam logic [TW-1:0] BEAT_LAST = TW'(BL - 1);

    // One committed column access travelling down a latency pipe
    typedef struct packed {
        logic          valid;
        logic [BW-1:0] bank;
        logic [CW-1:0] col;
    } col_req_t;

    logic [BW-1:0]                    w_bank;
    logic [CW-1:0]                    w_col;
    logic [ADR_ROW_W-1:0]             w_row;
    logic [NB-1:0]                    w_open, w_ready_act, w_ready_col;
    logic [NB-1:0]                    w_act_vec, w_pre_vec;
    bank_state_e [NB-1:0]             w_state;
    logic [NB-1:0][ADR_ROW_W-1:0]     w_rows;
    logic                             w_acc_act, w_acc_pre, w_acc_rd, w_acc_wr, w_rej;
    logic [2:0]                       w_rej_code;
    logic                             w_unused_bits;

    logic                             r_err;
    logic [2:0]                       r_err_code;
    logic [TW-1:0]                    r_ccd;
    col_req_t                         r_rd_pipe [CL];
    col_req_t                         r_wr_pipe [CWL];
    logic                             r_rd_valid;
    logic [DW-1:0]                    r_rd_dq;
    logic [TW-1:0]                    r_rd_cnt, r_wr_cnt;
    logic [BW-1:0]                    r_rd_bank, r_wr_bank;
    logic [CW-1:0]                    r_rd_col, r_wr_col;
    logic [DW-1:0]                    r_mem [NB*(2**CW)];

    logic                             w_rd_start, w_wr_start, w_wr_beat;
    logic [AW-1:0]                    w_rd_addr, w_wr_addr;

    assign w_bank = adrs[ADR_BANK_LSB +: BW];
    assign w_col  = adrs[CW-1:0];
    assign w_row  = adrs[ADR_ROW_LSB +: ADR_ROW_W];
    assign w_unused_bits = ^{adrs[31:ADR_BANK_LSB+BW], adrs[ADR_ROW_LSB-1:CW], w_state, w_rows};

    // Command decode with error priority; PRE on a closed bank is a silent no-op
    always_comb begin
        w_acc_act  = 1'b0;
        w_acc_pre  = 1'b0;
        w_acc_rd   = 1'b0;
        w_acc_wr   = 1'b0;
        w_rej      = 1'b0;
        w_rej_code = ERR_NONE;
        case (C_S)
            CMD_NOP: begin
            end
            CMD_ACT: begin
                if (w_open[w_bank]) begin
                    w_rej = 1'b1; w_rej_code = ERR_ACT_OPEN;
                end else if (!w_ready_act[w_bank]) begin
                    w_rej = 1'b1; w_rej_code = ERR_TRP;
                end else begin
                    w_acc_act = 1'b1;
                end
            end
            CMD_RD, CMD_WR: begin
                if (!w_open[w_bank]) begin
                    w_rej = 1'b1; w_rej_code = ERR_CLOSED;
                end else if (!w_ready_col[w_bank]) begin
                    w_rej = 1'b1; w_rej_code = ERR_TRCD;
                end else if (r_ccd != '0) begin
                    w_rej = 1'b1; w_rej_code = ERR_TCCD;
                end else if (C_S == CMD_RD) begin
                    w_acc_rd = 1'b1;
                end else begin
                    w_acc_wr = 1'b1;
                end
            end
            CMD_PRE: w_acc_pre = w_open[w_bank];
            default: begin
                w_rej = 1'b1; w_rej_code = ERR_ILLEGAL;
            end
        endcase
    end

    assign w_act_vec = w_acc_act ? (NB'(1) << w_bank) : '0;
    assign w_pre_vec = w_acc_pre ? (NB'(1) << w_bank) : '0;

    for (genvar g = 0; g < NB; g++) begin : g_bank
        dram_bank_fsm #(.TW(TW), .T_ACT(t_act), .T_PRE(t_pre)) u_bank (
            .clk         (clk),
            .rst         (rst),
            .i_act       (w_act_vec[g]),
            .i_pre       (w_pre_vec[g]),
            .i_row       (w_row),
            .o_open      (w_open[g]),
            .o_ready_act (w_ready_act[g]),
            .o_ready_col (w_ready_col[g]),
            .o_state     (w_state[g]),
            .o_row       (w_rows[g])
        );
    end

    // Error pulse, sticky error code and the global column-command spacing timer
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_ccd      <= '0;
        end else begin
            r_err <= w_rej;
            if (w_rej) r_err_code <= w_rej_code;
            if (w_acc_rd || w_acc_wr) r_ccd <= CCD_LOAD;
            else if (r_ccd != '0)     r_ccd <= r_ccd - TW'(1);
        end
    end

    // Latency pipes: stage 0 holds the access accepted on this edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CL; i++)  r_rd_pipe[i] <= '0;
            for (int i = 0; i < CWL; i++) r_wr_pipe[i] <= '0;
        end else begin
            r_rd_pipe[0] <= {w_acc_rd, w_bank, w_col};
            for (int i = 1; i < CL; i++)  r_rd_pipe[i] <= r_rd_pipe[i-1];
            r_wr_pipe[0] <= {w_acc_wr, w_bank, w_col};
            for (int i = 1; i < CWL; i++) r_wr_pipe[i] <= r_wr_pipe[i-1];
        end
    end

    assign w_rd_start = r_rd_pipe[CL-1].valid;
    assign w_rd_addr  = w_rd_start ? {r_rd_pipe[CL-1].bank, r_rd_pipe[CL-1].col}
                                   : {r_rd_bank, r_rd_col};
    assign w_wr_start = r_wr_pipe[CWL-1].valid;
    assign w_wr_beat  = w_wr_start || (r_wr_cnt != '0);
    assign w_wr_addr  = w_wr_start ? {r_wr_pipe[CWL-1].bank, r_wr_pipe[CWL-1].col}
                                   : {r_wr_bank, r_wr_col};

    // Read burst engine: one beat per cycle, column wraps inside the bank
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_valid <= 1'b0;
            r_rd_dq    <= '0;
            r_rd_cnt   <= '0;
            r_rd_bank  <= '0;
            r_rd_col   <= '0;
        end else if (w_rd_start) begin
            r_rd_valid <= 1'b1;
            r_rd_dq    <= r_mem[w_rd_addr];
            r_rd_cnt   <= BEAT_LAST;
            r_rd_bank  <= r_rd_pipe[CL-1].bank;
            r_rd_col   <= r_rd_pipe[CL-1].col + CW'(1);
        end else if (r_rd_cnt != '0) begin
            r_rd_valid <= 1'b1;
            r_rd_dq    <= r_mem[w_rd_addr];
            r_rd_cnt   <= r_rd_cnt - TW'(1);
            r_rd_col   <= r_rd_col + CW'(1);
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_dq    <= '0;
        end
    end

    // Write burst engine: tracks which word the current wr_dq beat lands in
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= '0;
            r_wr_col  <= '0;
        end else if (w_wr_start) begin
            r_wr_cnt  <= BEAT_LAST;
            r_wr_bank <= r_wr_pipe[CWL-1].bank;
            r_wr_col  <= r_wr_pipe[CWL-1].col + CW'(1);
        end else if (r_wr_cnt != '0) begin
            r_wr_cnt  <= r_wr_cnt - TW'(1);
            r_wr_col  <= r_wr_col + CW'(1);
        end
    end

    // Storage array survives reset; a reset edge cancels the beat in flight
    always_ff @(posedge clk) begin
        if (rst && w_wr_beat) r_mem[w_wr_addr] <= wr_dq;
    end

    assign rd_dq     = r_rd_dq;
    assign rd_valid  = r_rd_valid;
    assign bank_open = w_open;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_dram_cmd_resp.sv
// Bench for dram_cmd_resp: directed protocol scenarios followed by random
// command traffic, checked against a cycle-stamped behavioural device model.
module tb_dram_cmd_resp;

    localparam int NB    = 4;
    localparam int CL    = 4;
    localparam int CWL   = 3;
    localparam int BL    = 4;
    localparam int T_ACT = 8;
    localparam int T_PRE = 8;
    localparam int DW    = 8;
    localparam int CW    = 4;
    localparam int NCOL  = 1 << CW;
    localparam int WORDS = NB * NCOL;
    localparam int EW    = 1 + 32 + DW;

    localparam logic [3:0] C_NOP = 4'd0;
    localparam logic [3:0] C_ACT = 4'd1;
    localparam logic [3:0] C_RD  = 4'd2;
    localparam logic [3:0] C_WR  = 4'd3;
    localparam logic [3:0] C_PRE = 4'd4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    C_S = '0;
    logic [31:0]   adrs = '0;
    logic [DW-1:0] wr_dq = '0;
    logic [DW-1:0] rd_dq;
    logic          rd_valid;
    logic [NB-1:0] bank_open;
    logic          err;
    logic [2:0]    err_code;

    always #5 clk = ~clk;

    dram_cmd_resp #(
        .NB(NB), .CL(CL), .CWL(CWL), .BL(BL),
        .t_act(T_ACT), .t_pre(T_PRE), .DW(DW), .CW(CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .C_S       (C_S),
        .adrs      (adrs),
        .wr_dq     (wr_dq),
        .rd_dq     (rd_dq),
        .rd_valid  (rd_valid),
        .bank_open (bank_open),
        .err       (err),
        .err_code  (err_code)
    );

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cur_edge = -1;
    bit            started  = 1'b0;
    bit            exp_in_reset = 1'b0;
    logic [EW-1:0] exp_q[$];      // {data_known, edge, data}
    logic [34:0]   err_q[$];      // {edge, code}
    logic [NB-1:0] exp_bank_open = '0;
    logic [2:0]    exp_err_code  = '0;

    // ---------------- reference model ----------------
    bit            m_open    [NB];
    int            m_act_c   [NB];
    int            m_pre_c   [NB];
    int            m_last_col;
    logic [DW-1:0] m_mem     [WORDS];
    bit            m_written [WORDS];
    int            rd_due[int];   // edge -> word index read on that edge
    int            wr_due[int];   // edge -> word index written on that edge

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, cur_edge);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_open[i]  = 1'b0;
            m_act_c[i] = -1000;
            m_pre_c[i] = -1000;
        end
        m_last_col = -1000;
        rd_due.delete();
        wr_due.delete();
        exp_err_code  = '0;
        exp_bank_open = '0;
    endtask

    // Advance the model across edge n with the inputs being presented
    task automatic model_edge(input logic r, input logic [3:0] c, input logic [31:0] a,
                              input logic [DW-1:0] wd);
        int n, b, col, w;
        logic [2:0] code;
        n   = cur_edge;
        b   = int'(a[29:28]);
        col = int'(a[CW-1:0]);
        exp_in_reset = !r;
        if (!r) begin
            model_reset();
            return;
        end
        if (rd_due.exists(n)) begin
            w = rd_due[n];
            exp_q.push_back({m_written[w], 32'(n), m_mem[w]});
            rd_due.delete(n);
        end
        if (wr_due.exists(n)) begin
            w = wr_due[n];
            m_mem[w]     = wd;
            m_written[w] = 1'b1;
            wr_due.delete(n);
        end
        code = 3'd0;
        case (c)
            C_NOP: ;
            C_ACT: begin
                if (m_open[b])                       code = 3'd2;
                else if (n - m_pre_c[b] < T_PRE)     code = 3'd5;
                else begin
                    m_open[b]  = 1'b1;
                    m_act_c[b] = n;
                end
            end
            C_RD, C_WR: begin
                if (!m_open[b])                      code = 3'd3;
                else if (n - m_act_c[b] < T_ACT)     code = 3'd4;
                else if (n - m_last_col < BL)        code = 3'd6;
                else begin
                    m_last_col = n;
                    for (int k = 0; k < BL; k++) begin
                        if (c == C_RD) rd_due[n + CL + k]  = b * NCOL + ((col + k) % NCOL);
                        else           wr_due[n + CWL + k] = b * NCOL + ((col + k) % NCOL);
                    end
                end
            end
            C_PRE: begin
                if (m_open[b]) begin
                    m_open[b]  = 1'b0;
                    m_pre_c[b] = n;
                end
            end
            default: code = 3'd1;
        endcase
        if (code != 3'd0) begin
            err_q.push_back({32'(n), code});
            exp_err_code = code;
        end
        for (int i = 0; i < NB; i++) exp_bank_open[i] = m_open[i];
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic r, input logic [3:0] c, input int b, input int col,
                        input logic [DW-1:0] wd);
        logic [31:0] a;
        @(negedge clk);
        a = $urandom;
        a[29:28]  = 2'(b);
        a[CW-1:0] = CW'(col);
        rst   = r;
        C_S   = c;
        adrs  = a;
        wr_dq = wd;
        cur_edge++;
        model_edge(r, c, a, wd);
        started = 1'b1;
    endtask

    task automatic nop(input int k);
        for (int i = 0; i < k; i++) step(1'b1, C_NOP, 0, 0, DW'($urandom));
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e;
        logic [34:0]   ee;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                check("bank_open", 64'(bank_open), 64'(exp_bank_open));
                check("err_code", 64'(err_code), 64'(exp_err_code));
                if (exp_in_reset) begin
                    check("reset_rd_valid", 64'(rd_valid), 64'(0));
                    check("reset_err", 64'(err), 64'(0));
                    check("reset_rd_dq", 64'(rd_dq), 64'(0));
                end
                if (err) begin
                    if (err_q.size() == 0) begin
                        check("err_unexpected", 64'(err), 64'(0));
                    end else begin
                        ee = err_q.pop_front();
                        check("err_edge", 64'(cur_edge), 64'(ee[34:3]));
                        check("err_pulse_code", 64'(err_code), 64'(ee[2:0]));
                    end
                end
                if (rd_valid) begin
                    if (exp_q.size() == 0) begin
                        check("rd_unexpected", 64'(rd_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("rd_beat_edge", 64'(cur_edge), 64'(e[DW+31:DW]));
                        if (e[EW-1]) check("rd_data", 64'(rd_dq), 64'(e[DW-1:0]));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] c;
        logic       r;
        int         p;
        model_reset();
        for (int i = 0; i < WORDS; i++) m_written[i] = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, C_NOP, 0, 0, '0);
        nop(2);

        // Write then read back bank0 col2 with A0..A3
        step(1'b1, C_ACT, 0, 0, '0);
        nop(7);
        step(1'b1, C_WR, 0, 2, '0);
        nop(2);
        step(1'b1, C_NOP, 0, 0, 8'hA0);
        step(1'b1, C_RD,  0, 2, 8'hA1);
        step(1'b1, C_NOP, 0, 0, 8'hA2);
        step(1'b1, C_NOP, 0, 0, 8'hA3);
        nop(10);

        // Column command on a closed bank
        step(1'b1, C_RD, 1, 0, '0);
        nop(3);

        // tRCD: too early, then exactly on time
        step(1'b1, C_ACT, 2, 0, '0);
        nop(4);
        step(1'b1, C_RD, 2, 0, '0);
        nop(2);
        step(1'b1, C_RD, 2, 0, '0);
        nop(8);

        // tRP: too early, then exactly on time
        step(1'b1, C_ACT, 3, 0, '0);
        nop(8);
        step(1'b1, C_PRE, 3, 0, '0);
        nop(3);
        step(1'b1, C_ACT, 3, 0, '0);
        nop(3);
        step(1'b1, C_ACT, 3, 0, '0);
        nop(2);

        // tCCD: too close, then back-to-back bursts
        step(1'b1, C_RD, 0, 2, '0);
        nop(1);
        step(1'b1, C_RD, 0, 2, '0);
        nop(4);
        step(1'b1, C_RD, 0, 2, '0);
        nop(3);
        step(1'b1, C_RD, 0, 14, '0);
        nop(12);

        // Illegal command, reset mid read burst, data survives reset
        step(1'b1, 4'd9, 0, 0, '0);
        step(1'b1, C_RD, 0, 2, '0);
        nop(CL + 1);
        step(1'b0, C_NOP, 0, 0, '0);
        nop(1);
        step(1'b1, C_ACT, 0, 0, '0);
        nop(7);
        step(1'b1, C_RD, 0, 2, '0);
        nop(10);

        // Random traffic
        for (int it = 0; it < 1500; it++) begin
            p = $urandom_range(0, 99);
            if (p < 25)      c = C_NOP;
            else if (p < 40) c = C_ACT;
            else if (p < 60) c = C_RD;
            else if (p < 78) c = C_WR;
            else if (p < 90) c = C_PRE;
            else if (p < 97) c = C_NOP;
            else             c = 4'($urandom_range(5, 15));
            r = ($urandom_range(0, 299) != 0);
            step(r, c, $urandom_range(0, NB - 1), $urandom_range(0, NCOL - 1), DW'($urandom));
        end

        nop(20);
        @(posedge clk);
        #2;
        check("rd_queue_drained", 64'(exp_q.size()), 64'(0));
        check("err_queue_drained", 64'(err_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
